// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand class codes, extended-mantissa geometry.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fp_pkg;

    // Operand class codes produced by the classifier
    localparam logic [2:0] TYPE_ZERO = 3'd0;
    localparam logic [2:0] TYPE_SUB  = 3'd1;
    localparam logic [2:0] TYPE_NORM = 3'd2;
    localparam logic [2:0] TYPE_INF  = 3'd3;
    localparam logic [2:0] TYPE_NAN  = 3'd4;

    // Guard/round/sticky bits appended below the fraction
    localparam int GRS_W      = 3;
    localparam int STICKY_POS = 0;
    localparam int ROUND_POS  = 1;
    localparam int GUARD_POS  = 2;

    // Overflow + hidden bit above the fraction, GRS below it
    localparam int EXT_OVH = 2 + GRS_W;

    function automatic int ext_width(input int man_w);
        return man_w + EXT_OVH;
    endfunction

    function automatic int hidden_pos(input int man_w);
        return man_w + GRS_W;
    endfunction

endpackage

// File: rtl/fp_sticky_shifter.sv
// Logical right shifter that folds every shifted-out bit into the sticky (LSB) position.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: din (W) value to shift, shamt (SH_W) shift distance, dout (W) shifted value.
// Shifts of W or more saturate to a lone sticky bit carrying the OR of the whole input.
module fp_sticky_shifter
    import fp_pkg::*;
#(
    parameter int W    = 28,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    dout
);

    logic [W-1:0] lost_mask;
    logic         sticky;

    always_comb begin
        // Bits below the shift distance fall off; bit 0 always contributes to sticky
        lost_mask    = ~({W{1'b1}} << shamt);
        lost_mask[0] = 1'b1;
        sticky       = |(din & lost_mask);
        dout         = '0;
        if (32'(shamt) >= W) begin
            dout[STICKY_POS] = |din;
        end else begin
            dout             = din >> shamt;
            dout[STICKY_POS] = dout[STICKY_POS] | sticky;
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage operand alignment for the FP adder: extend, exponent-compare, sticky shift, order by magnitude.
// Latency: 2 cycles from accepted input to out_valid; 1 pair/cycle throughput.
// Backpressure: valid/ready both sides; each stage advances when its successor is empty or draining.
// Ports: clk/rst (sync active-high); in_valid/in_ready with sign_*, exp_*, man_*, type_*, tag_in;
//        out_valid/out_ready with sign_great/small, exp_out, man_great/small, type_great/small, eq_mag, tag_out.
module fp_align_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    parameter  int TAG_W = 4,
    localparam int EXT_W = ext_width(MAN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    input  logic [2:0]       type_a,
    input  logic [2:0]       type_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_great,
    output logic             sign_small,
    output logic [EXP_W-1:0] exp_out,
    output logic [EXT_W-1:0] man_great,
    output logic [EXT_W-1:0] man_small,
    output logic [2:0]       type_great,
    output logic [2:0]       type_small,
    output logic             eq_mag,
    output logic [TAG_W-1:0] tag_out
);

    function automatic logic [EXT_W-1:0] extend(input logic [2:0] t, input logic [MAN_W-1:0] m);
        logic [EXT_W-1:0] r;
        case (t)
            TYPE_ZERO: r = '0;
            TYPE_SUB:  r = {2'b00, m, {GRS_W{1'b0}}};
            TYPE_NORM, TYPE_INF, TYPE_NAN: r = {2'b01, m, {GRS_W{1'b0}}};
            default:   r = {2'b01, m, {GRS_W{1'b0}}};
        endcase
        return r;
    endfunction

    // ---------------- stage 1: extend, compare exponents, route ----------------
    // x = larger-exponent operand (no shift), y = smaller-exponent operand (shifted)
    logic             s1_valid;
    logic [EXP_W-1:0] s1_exp;
    logic [EXP_W-1:0] s1_diff;
    logic             s1_b_big;
    logic [EXT_W-1:0] s1_man_x;
    logic [EXT_W-1:0] s1_man_y;
    logic             s1_sign_a;
    logic             s1_sign_b;
    logic [2:0]       s1_type_a;
    logic [2:0]       s1_type_b;
    logic [TAG_W-1:0] s1_tag;

    logic [EXP_W-1:0] eff_a;
    logic [EXP_W-1:0] eff_b;
    logic [EXT_W-1:0] ext_a;
    logic [EXT_W-1:0] ext_b;
    logic             b_big;
    logic             s2_take;

    always_comb begin
        eff_a = (type_a == TYPE_SUB) ? EXP_W'(1) : exp_a;
        eff_b = (type_b == TYPE_SUB) ? EXP_W'(1) : exp_b;
        ext_a = extend(type_a, man_a);
        ext_b = extend(type_b, man_b);
        b_big = eff_b > eff_a;          // A keeps the exponent tie
    end

    // Output register can take new data when empty or being drained this cycle
    assign s2_take  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_exp    <= '0;
            s1_diff   <= '0;
            s1_b_big  <= 1'b0;
            s1_man_x  <= '0;
            s1_man_y  <= '0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_type_a <= '0;
            s1_type_b <= '0;
            s1_tag    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_b_big  <= b_big;
                s1_exp    <= b_big ? eff_b : eff_a;
                s1_diff   <= b_big ? (eff_b - eff_a) : (eff_a - eff_b);
                s1_man_x  <= b_big ? ext_b : ext_a;
                s1_man_y  <= b_big ? ext_a : ext_b;
                s1_sign_a <= sign_a;
                s1_sign_b <= sign_b;
                s1_type_a <= type_a;
                s1_type_b <= type_b;
                s1_tag    <= tag_in;
            end
        end
    end

    // ---------------- stage 2: align, compare magnitudes, order ----------------
    logic [EXT_W-1:0] man_y_al;
    logic             y_wins;
    logic             sel_b;

    fp_sticky_shifter #(
        .W    (EXT_W),
        .SH_W (EXP_W)
    ) u_shift (
        .din   (s1_man_y),
        .shamt (s1_diff),
        .dout  (man_y_al)
    );

    always_comb begin
        // On equal magnitudes the A operand must win: y is A exactly when B had the larger exponent
        y_wins = s1_b_big ? (man_y_al >= s1_man_x) : (man_y_al > s1_man_x);
        sel_b  = s1_b_big ^ y_wins;    // 1: B is the larger magnitude
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            sign_great <= 1'b0;
            sign_small <= 1'b0;
            exp_out    <= '0;
            man_great  <= '0;
            man_small  <= '0;
            type_great <= '0;
            type_small <= '0;
            eq_mag     <= 1'b0;
            tag_out    <= '0;
        end else if (s2_take) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sign_great <= sel_b ? s1_sign_b : s1_sign_a;
                sign_small <= sel_b ? s1_sign_a : s1_sign_b;
                type_great <= sel_b ? s1_type_b : s1_type_a;
                type_small <= sel_b ? s1_type_a : s1_type_b;
                man_great  <= y_wins ? man_y_al : s1_man_x;
                man_small  <= y_wins ? s1_man_x : man_y_al;
                eq_mag     <= (man_y_al == s1_man_x);
                exp_out    <= s1_exp;
                tag_out    <= s1_tag;
            end
        end
    end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined operand-alignment stage for the floating-point adder/subtractor.
- Per operand pair, the block:
  - extends both mantissas with overflow, hidden, guard, round and sticky bits;
  - computes effective exponents, handling subnormals;
  - right-shifts the smaller-exponent mantissa with sticky collection;
  - orders the operands by magnitude.
- Sits between the operand classifier and the mantissa add/normalise stage, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width.
- TAG_W, 4, width of the user tag carried alongside the data.
- EXT_W (localparam), MAN_W+5: overflow + hidden + fraction + guard/round/sticky.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- sign_a, sign_b  in  1 each  operand signs.
- exp_a, exp_b  in  EXP_W each  biased exponents.
- man_a, man_b  in  MAN_W each  stored fractions.
- type_a, type_b  in  3 each  class codes: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 NaN.
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- sign_great, sign_small  out  1 each  signs of the larger and smaller magnitude.
- exp_out  out  EXP_W  common (larger) effective exponent.
- man_great, man_small  out  EXT_W each  aligned mantissas, man_great >= man_small.
- type_great, type_small  out  3 each  class codes, swapped with the mantissas.
- eq_mag  out  1  aligned magnitudes equal.
- tag_out  out  TAG_W  tag delivered with its own result.

Behaviour:
- Reset (synchronous, active-high): all outputs and internal stage registers clear to 0, including out_valid and both stage valids. In-flight data is discarded. in_ready is 1 in the first cycle after reset.
- Extension rule:
  - normal: {1'b0, 1'b1, man, 3'b000};
  - subnormal: {1'b0, 1'b0, man, 3'b000};
  - zero: all zeros;
  - inf/NaN: treated as normal; downstream decides using the type codes.
- Effective exponent = 1 for subnormal, otherwise the raw exp.
- Stage 1 (registered):
  - effective exponents and extended mantissas;
  - exponent compare: A wins ties;
  - diff = larger − smaller, EXP_W bits, unsigned;
  - routing into a shift path and a non-shift path.
- Stage 2 (registered):
  - logical right shift of the shift-path mantissa by diff.
  - Bit 0 of the result = OR of every bit shifted out, ORed with the original bit 0 (sticky).
  - If diff >= EXT_W: result is all zeros except bit 0 = OR of the whole input.
  - Then an unsigned magnitude compare of the two aligned mantissas.
  - Larger goes to man_great; A-side wins ties, where A-side means the operand from input A.
  - Signs and types follow their mantissas: sign select = exponent-compare code XOR mantissa-compare code.
  - eq_mag = 1 when the aligned mantissas are equal.
  - exp_out = larger effective exponent.
- Latency: 2 cycles from an accepted input to out_valid when never stalled. Throughput 1 pair per cycle.
- Handshake:
  - Transfer occurs when valid && ready, on either side.
  - Outputs hold stable while out_valid && !out_ready.
  - A stage advances when its successor is empty or is advancing.
  - in_ready = !s1_valid || s1_advance; this is combinational from out_ready.
  - No bubbles are inserted under continuous flow. No loss or duplication under any stall pattern. Order is preserved.
- Simultaneous accept-in and accept-out in a full pipe: both occur in the same cycle.
- in_valid while in_ready = 0: ignored. The upstream must hold its data.

Decomposition:
- Shared package fp_pkg holds:
  - the class-code constants (TYPE_ZERO, TYPE_SUB, TYPE_NORM, TYPE_INF, TYPE_NAN);
  - EXT_W derivation helpers;
  - GRS bit-position constants.
- One natural sub-module: fp_sticky_shifter. It is a parametrised right shifter with sticky OR and saturation at EXT_W, instantiated in stage 2.

Test Plan:
- 1.0 + 0.5:
  - Stimulus: exp_a=127, man_a=0, type normal; exp_b=126, man_b=0, type normal.
  - Expect after 2 cycles: exp_out=127, man_great=28'h4000000, man_small=28'h2000000, eq_mag=0.
- Large difference:
  - Stimulus: exp_a=150, exp_b=100, both normal, man_b=1.
  - Expect: man_small=28'h0000001 (sticky only); man_great is A's extended mantissa.
- Tie in magnitude:
  - Stimulus: A = −2.0 (sign 1, exp 128), B = +2.0.
  - Expect: sign_great=1, sign_small=0, eq_mag=1, tag follows.
- Subnormal against the smallest normal:
  - Stimulus: A subnormal (exp 0, man 23'h400000); B normal (exp 1, man 0).
  - Expect: exp_out=1, diff 0, man_great=28'h4000000 (B), man_small=28'h2000000 (A), type_great=2.
- Backpressure:
  - Stimulus: stream tags 1..5 with out_ready held low for 4 cycles.
  - Expect: in_ready drops after 2 pairs are accepted; outputs stay stable; tags emerge 1..5 in order with none lost.
- Reset mid-stream:
  - Stimulus: rst asserted for one cycle with 2 items in flight.
  - Expect: next cycle out_valid=0, all outputs 0, in_ready=1; neither flushed item ever appears.
